// File: rtl/operand_builder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_builder_pkg
// Description : Key codes, operator codes, display words and FSM encoding
//               shared by the operand builder.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_builder_pkg;

    localparam logic [4:0] c_key_digit_max = 5'd9;
    localparam logic [4:0] c_key_plus      = 5'd10;
    localparam logic [4:0] c_key_minus     = 5'd11;
    localparam logic [4:0] c_key_mul       = 5'd12;
    localparam logic [4:0] c_key_div       = 5'd13;
    localparam logic [4:0] c_key_mod       = 5'd14;
    localparam logic [4:0] c_key_equal     = 5'd15;
    localparam logic [4:0] c_key_sign      = 5'd16;
    localparam logic [4:0] c_key_clear     = 5'd17;
    localparam logic [4:0] c_key_none      = 5'd31;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_mul = 3'd2;
    localparam logic [2:0] c_op_div = 3'd3;
    localparam logic [2:0] c_op_mod = 3'd4;

    localparam logic [31:0] c_disp_err = 32'h00EE_0000;

    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OPR  = 3'd1,
        S_OP2  = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    function automatic logic [2:0] op_from_key(input logic [4:0] code);
        logic [2:0] op;
        case (code)
            c_key_plus:  op = c_op_add;
            c_key_minus: op = c_op_sub;
            c_key_mul:   op = c_op_mul;
            c_key_div:   op = c_op_div;
            c_key_mod:   op = c_op_mod;
            default:     op = c_op_add;
        endcase
        return op;
    endfunction

    // Operator word shows (operator+1) in the third nibble from the top.
    function automatic logic [31:0] op_word(input logic [2:0] op);
        logic [3:0] nib;
        nib = {1'b0, op} + 4'd1;
        if (op > c_op_mod) begin
            return c_disp_err;
        end
        return {8'h00, nib, 20'h0_0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_builder_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_builder_if
// Description : Keypad/calculator bundle between the operand builder and
//               its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_builder_if;

    logic        [4:0]  eBCD;
    logic signed [31:0] result;
    logic signed [31:0] operand1;
    logic signed [31:0] operand2;
    logic        [2:0]  operator;
    logic signed [31:0] fnd_serial;

    modport master (
        output eBCD,
        output result,
        input  operand1,
        input  operand2,
        input  operator,
        input  fnd_serial
    );

    modport slave (
        input  eBCD,
        input  result,
        output operand1,
        output operand2,
        output operator,
        output fnd_serial
    );

endinterface
`default_nettype wire

// File: rtl/operand_builder_key_edge.sv
`default_nettype none
// ============================================================================
// Module      : operand_builder_key_edge
// Description : Registers the keypad code and strobes once per key press.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_builder_key_edge
    import operand_builder_pkg::*;
(
    input  logic       sw_clk,
    input  logic       rst,
    input  logic [4:0] i_ebcd,
    output logic [4:0] o_code,
    output logic       o_press
);

    logic [4:0] r_code;
    logic [4:0] r_prev;

    always_ff @(posedge sw_clk or posedge rst) begin
        if (rst) begin
            r_code <= c_key_none;
            r_prev <= c_key_none;
        end else begin
            r_code <= i_ebcd;
            r_prev <= r_code;
        end
    end

    // A held key stays a single event until the pad returns to "no key".
    assign o_code  = r_code;
    assign o_press = (r_prev == c_key_none) && (r_code != c_key_none);

endmodule
`default_nettype wire

// File: rtl/operand_builder.sv
`default_nettype none
// ============================================================================
// Module      : operand_builder
// Description : Builds signed operands and operator from keypad presses and
//               drives the display word. OPERAND_CHAIN_EN lets an operator
//               key after a result continue from that result.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_builder
    import operand_builder_pkg::*;
#(
    parameter int MAX_DIGITS = 5
)
(
    input logic              sw_clk,
    input logic              rst,
    operand_builder_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [4:0]       w_code;
    logic             w_press;
    logic             w_digit;
    logic             w_opkey;
    logic             w_equal;
    logic             w_sign;
    logic             w_clear;
    logic [2:0]       w_op;
    logic [31:0]      w_digit_val;
    logic [31:0]      w_acc_mag;
    logic [CNT_W-1:0] w_acc_cnt;
    logic [31:0]      w_buf_signed;

    state_t           r_state;
    logic [31:0]      r_mag;
    logic             r_neg;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_operand1;
    logic [31:0]      r_operand2;
    logic [2:0]       r_operator;
    logic [31:0]      r_fnd;

    operand_builder_key_edge u_key_edge (
        .sw_clk  (sw_clk),
        .rst     (rst),
        .i_ebcd  (bus.eBCD),
        .o_code  (w_code),
        .o_press (w_press)
    );

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    assign w_digit     = w_press && (w_code <= c_key_digit_max);
    assign w_opkey     = w_press && (w_code >= c_key_plus) && (w_code <= c_key_mod);
    assign w_equal     = w_press && (w_code == c_key_equal);
    assign w_sign      = w_press && (w_code == c_key_sign);
    assign w_clear     = w_press && (w_code == c_key_clear);
    assign w_op        = op_from_key(w_code);
    assign w_digit_val = {28'd0, w_code[3:0]};
    assign w_buf_signed = apply_sign(r_mag, r_neg);

    // Leading zeros keep the count at zero so they never use up digit slots.
    always_comb begin
        w_acc_mag = r_mag;
        w_acc_cnt = r_count;
        if (r_count < c_max_cnt) begin
            w_acc_mag = (r_mag << 3) + (r_mag << 1) + w_digit_val;
            if (!((r_mag == 32'd0) && (w_code[3:0] == 4'd0))) begin
                w_acc_cnt = r_count + c_cnt_one;
            end
        end
    end

    always_ff @(posedge sw_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_OP1;
            r_mag      <= '0;
            r_neg      <= 1'b0;
            r_count    <= '0;
            r_operand1 <= '0;
            r_operand2 <= '0;
            r_operator <= c_op_add;
            r_fnd      <= '0;
        end else if (w_clear) begin
            r_state    <= S_OP1;
            r_mag      <= '0;
            r_neg      <= 1'b0;
            r_count    <= '0;
            r_operand1 <= '0;
            r_operand2 <= '0;
            r_operator <= c_op_add;
            r_fnd      <= '0;
        end else begin
            case (r_state)
                S_OP1, S_OP2: begin
                    if (w_digit) begin
                        r_mag   <= w_acc_mag;
                        r_count <= w_acc_cnt;
                        r_fnd   <= apply_sign(w_acc_mag, r_neg);
                    end else if (w_sign) begin
                        r_neg <= ~r_neg;
                        r_fnd <= apply_sign(r_mag, ~r_neg);
                    end else if (w_opkey) begin
                        r_operator <= w_op;
                        if (r_state == S_OP1) begin
                            r_operand1 <= w_buf_signed;
                            r_mag      <= '0;
                            r_neg      <= 1'b0;
                            r_count    <= '0;
                            r_fnd      <= op_word(w_op);
                            r_state    <= S_OPR;
                        end
                    end else if (w_equal && (r_state == S_OP2)) begin
                        r_operand2 <= w_buf_signed;
                        r_state    <= S_CALC;
                    end
                end
                S_OPR: begin
                    if (w_digit) begin
                        r_mag   <= w_digit_val;
                        r_neg   <= 1'b0;
                        r_count <= (w_code[3:0] != 4'd0) ? c_cnt_one : '0;
                        r_fnd   <= w_digit_val;
                        r_state <= S_OP2;
                    end else if (w_opkey) begin
                        r_operator <= w_op;
                        r_fnd      <= op_word(w_op);
                    end
                end
                S_CALC: begin
                    r_fnd   <= bus.result;
                    r_state <= S_RES;
                end
                S_RES: begin
                    if (w_digit) begin
                        r_mag      <= w_digit_val;
                        r_neg      <= 1'b0;
                        r_count    <= (w_code[3:0] != 4'd0) ? c_cnt_one : '0;
                        r_operand1 <= '0;
                        r_operand2 <= '0;
                        r_operator <= c_op_add;
                        r_fnd      <= w_digit_val;
                        r_state    <= S_OP1;
                    end
`ifdef OPERAND_CHAIN_EN
                    else if (w_opkey) begin
                        r_operand1 <= r_fnd;
                        r_operator <= w_op;
                        r_mag      <= '0;
                        r_neg      <= 1'b0;
                        r_count    <= '0;
                        r_fnd      <= op_word(w_op);
                        r_state    <= S_OPR;
                    end
`endif
                end
                default: r_state <= S_OP1;
            endcase
        end
    end

    assign bus.operand1   = r_operand1;
    assign bus.operand2   = r_operand2;
    assign bus.operator   = r_operator;
    assign bus.fnd_serial = r_fnd;

endmodule
`default_nettype wire
